sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 96 +++++++++
 tb/tb_sram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: data over inst, inst forced through after STARVE_MAX contended data grants.
// Grant is combinational, response one cycle later; the loser simply holds its request (nothing is queued).
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [3:0]  inst_wen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       inst_win;
    logic       data_win;

    // Grants are gated by resetn so nothing is granted while reset is held.
    always_comb begin
        inst_win = resetn && inst_req && (!data_req || (starve_cnt == STARVE_LIM));
        data_win = resetn && data_req && !inst_win;
    end

    assign inst_addr_ok = inst_win;
    assign data_addr_ok = data_win;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (inst_win) begin
            sram_en    = 1'b1;
            sram_wen   = inst_wen;
            sram_addr  = inst_addr;
            sram_wdata = inst_wdata;
        end else if (data_win) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    always_comb begin
        inst_data_ok = (state == RESP_I) && !inst_cancel;
        data_data_ok = (state == RESP_D);
        inst_rdata   = (state == RESP_I) ? sram_rdata : 32'h0;
        data_rdata   = (state == RESP_D) ? sram_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            if (inst_win)
                state <= RESP_I;
            else if (data_win)
                state <= RESP_D;
            else
                state <= IDLE;

            // Counts only contended data grants; any idle-inst cycle resets the streak.
            if (!inst_req || inst_win)
                starve_cnt <= 4'd0;
            else if (data_win && (starve_cnt < STARVE_LIM))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, idle, single access, write, contention, cancel, async reset.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cancel;
    logic [3:0]  inst_wen;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    function automatic logic [3:0] oks();
        return {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
    endfunction

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wen = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_i, prev_i, prev_d;

        // Reset with both requesters active: nothing may be granted or returned.
        resetn = 1'b0;
        idle_inputs();
        inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h44; data_addr = 32'h88;
        sram_rdata = 32'hDEADBEEF;
        #3;
        chk("reset_oks", {28'h0, oks()}, 32'h0);
        chk("reset_sram_en", {31'h0, sram_en}, 32'h0);
        chk("reset_sram_wen", {28'h0, sram_wen}, 32'h0);
        chk("reset_inst_rdata", inst_rdata, 32'h0);
        chk("reset_data_rdata", data_rdata, 32'h0);
        sample();
        idle_inputs();
        resetn = 1'b1;

        // Three idle cycles.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            chk("idle_sram_en", {31'h0, sram_en}, 32'h0);
            chk("idle_oks", {28'h0, oks()}, 32'h0);
            chk("idle_starve", {28'h0, dut.starve_cnt}, 32'h0);
        end

        // Single inst read.
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        sample();
        chk("inst_rd_grant", {28'h0, oks()}, 32'h8);
        chk("inst_rd_en", {31'h0, sram_en}, 32'h1);
        chk("inst_rd_addr", sram_addr, 32'hBFC00000);
        chk("inst_rd_wen", {28'h0, sram_wen}, 32'h0);
        next_cycle();
        idle_inputs();
        sram_rdata = 32'hCAFEF00D;
        sample();
        chk("inst_rd_resp_oks", {28'h0, oks()}, 32'h2);
        chk("inst_rd_rdata", inst_rdata, 32'hCAFEF00D);
        chk("inst_rd_data_rdata", data_rdata, 32'h0);

        // Data write.
        next_cycle();
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h10; data_wdata = 32'h12345678;
        sample();
        chk("dwr_grant", {28'h0, oks()}, 32'h4);
        chk("dwr_wen", {28'h0, sram_wen}, 32'h3);
        chk("dwr_addr", sram_addr, 32'h10);
        chk("dwr_wdata", sram_wdata, 32'h12345678);
        next_cycle();
        idle_inputs();
        sram_rdata = 32'h0BADF00D;
        sample();
        chk("dwr_resp_oks", {28'h0, oks()}, 32'h1);
        chk("dwr_resp_rdata", data_rdata, 32'h0BADF00D);
        chk("dwr_resp_inst_rdata", inst_rdata, 32'h0);

        // Full contention: D,D,D,D,I repeating.
        prev_i = 1'b0; prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            inst_req = 1'b1; inst_addr = 32'h100;
            data_req = 1'b1; data_addr = 32'h200;
            sram_rdata = 32'h1000 + i;
            exp_i = (i % 5 == 4);
            sample();
            chk("cont_oks", {28'h0, oks()}, {28'h0, exp_i, ~exp_i, prev_i, prev_d});
            chk("cont_addr", sram_addr, exp_i ? 32'h100 : 32'h200);
            chk("cont_inst_rdata", inst_rdata, prev_i ? 32'h1000 + i : 32'h0);
            chk("cont_data_rdata", data_rdata, prev_d ? 32'h1000 + i : 32'h0);
            prev_i = exp_i; prev_d = ~exp_i;
        end
        next_cycle();
        idle_inputs();
        sample();
        chk("cont_tail_oks", {28'h0, oks()}, 32'h2);
        chk("cont_tail_starve", {28'h0, dut.starve_cnt}, 32'h0);

        // Cancel of an old inst response alongside a new inst grant.
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h300;
        sample();
        chk("cancel_g1", {28'h0, oks()}, 32'h8);
        next_cycle();
        inst_addr = 32'h304; inst_cancel = 1'b1;
        sample();
        chk("cancel_oks", {28'h0, oks()}, 32'h8);
        chk("cancel_addr", sram_addr, 32'h304);
        next_cycle();
        idle_inputs();
        sample();
        chk("cancel_g2_resp", {28'h0, oks()}, 32'h2);

        // Starvation counter builds under contention, then clears when inst drops.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            inst_req = 1'b1; data_req = 1'b1;
        end
        next_cycle();
        idle_inputs();
        chk("starve_two", {28'h0, dut.starve_cnt}, 32'h2);
        next_cycle();
        chk("starve_clear", {28'h0, dut.starve_cnt}, 32'h0);

        // Reset mid-response: data_ok must drop at once.
        next_cycle();
        inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h20;
        sample();
        chk("rst_dgrant", {28'h0, oks()}, 32'h4);
        next_cycle();
        idle_inputs();
        chk("rst_pre_ok", {31'h0, data_data_ok}, 32'h1);
        chk("rst_pre_starve", {28'h0, dut.starve_cnt}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_ok", {31'h0, data_data_ok}, 32'h0);
        chk("rst_async_starve", {28'h0, dut.starve_cnt}, 32'h0);
        next_cycle();
        sample();
        resetn = 1'b1;
        next_cycle();
        data_req = 1'b1; data_addr = 32'h24;
        sample();
        chk("rst_first_grant", {28'h0, oks()}, 32'h4);
        next_cycle();
        idle_inputs();
        sample();
        chk("rst_first_resp", {28'h0, oks()}, 32'h1);
        next_cycle();
        sample();
        chk("rst_quiet", {28'h0, oks()}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
